// File: rtl/timer_if.sv
// timer <-> fsm bundle
// fsm drives restart/programming; timer returns expiry and countdown
interface timer_if;
  logic       start_t;
  logic [1:0] interval;
  logic       prog_sync;
  logic [1:0] time_param_sel;
  logic [3:0] time_value;
  logic       expired;
  logic [3:0] seconds_left;

  modport master (
    output start_t,
    output interval,
    output prog_sync,
    output time_param_sel,
    output time_value,
    input  expired,
    input  seconds_left
  );

  modport slave (
    input  start_t,
    input  interval,
    input  prog_sync,
    input  time_param_sel,
    input  time_value,
    output expired,
    output seconds_left
  );
endinterface

// File: rtl/timer.sv
// Interval timer for the traffic-light fsm
// Holds the three phase durations and counts down the selected one
module timer #(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int T_BASE_RST    = 6,
  parameter int T_EXT_RST     = 3,
  parameter int T_YEL_RST     = 2
) (
  input  logic   clk,
  input  logic   reset_n,
  timer_if.slave bus
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    secs_q, secs_d;
  logic          exp_q, exp_d;
  logic [3:0]    base_q, base_d;
  logic [3:0]    ext_q, ext_d;
  logic [3:0]    yel_q, yel_d;
  logic [3:0]    wr_val;
  logic [3:0]    sel_dur;
  logic          tick;

  assign bus.expired      = exp_q;
  assign bus.seconds_left = secs_q;

  // Duration writes from the programming path; zero is promoted to one
  always_comb begin
    base_d = base_q;
    ext_d  = ext_q;
    yel_d  = yel_q;
    wr_val = (bus.time_value == 4'd0) ? 4'd1 : bus.time_value;
    if (bus.prog_sync) begin
      case (bus.time_param_sel)
        2'b00:   base_d = wr_val;
        2'b01:   ext_d  = wr_val;
        2'b10:   yel_d  = wr_val;
        default: ;
      endcase
    end
  end

  // Duration chosen for a restart, taken from pre-edge register values
  always_comb begin
    sel_dur = base_q;
    case (bus.interval)
      2'b01:   sel_dur = ext_q;
      2'b10:   sel_dur = yel_q;
      default: sel_dur = base_q;
    endcase
  end

  assign tick = (state_q == RUN) && (presc_q == PMAX) && !bus.start_t;

  // Next state: restart beats expiry; prescaler idles at zero
  always_comb begin
    state_d = state_q;
    secs_d  = secs_q;
    presc_d = '0;
    exp_d   = 1'b0;
    if (bus.start_t) begin
      secs_d  = sel_dur;
      state_d = RUN;
    end else if (state_q == RUN) begin
      if (tick) begin
        if (secs_q > 4'd1) begin
          secs_d = secs_q - 4'd1;
        end else begin
          secs_d  = 4'd0;
          exp_d   = 1'b1;
          state_d = IDLE;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // Countdown state and expiry pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      secs_q  <= 4'd0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      secs_q  <= secs_d;
      exp_q   <= exp_d;
    end
  end

  // Programmable duration registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q <= 4'(T_BASE_RST);
      ext_q  <= 4'(T_EXT_RST);
      yel_q  <= 4'(T_YEL_RST);
    end else begin
      base_q <= base_d;
      ext_q  <= ext_d;
      yel_q  <= yel_d;
    end
  end

endmodule
